// File: rtl/act_lut_pingpong_if.sv
// Lane read bus, host BRAM-controller port and swap control for act_lut_pingpong.
// Optional host readback signals exist only when ACT_LUT_READBACK_EN is defined.
interface act_lut_pingpong_if #(
  parameter int LANES       = 32,
  parameter int LUT_WIDTH   = 24,
  parameter int ADDR_WIDTH  = 4,
  parameter int WDATA_WIDTH = 32
);
  logic [LANES*ADDR_WIDTH-1:0] i_lut_raddr;
  logic                        i_lut_rd_en;
  logic [LANES*LUT_WIDTH-1:0]  o_lut_dat;
  logic                        o_lut_dat_vld;
  logic [WDATA_WIDTH-1:0]      i_lut_bramctl_wdata;
  logic [ADDR_WIDTH-1:0]       i_lut_bramctl_addr;
  logic                        i_lut_bramctl_we;
  logic                        i_lut_bramctl_en;
  logic                        i_swap_req;
  logic                        o_swap_busy;
  logic                        o_active_bank;
  logic                        o_wr_err;
`ifdef ACT_LUT_READBACK_EN
  logic [WDATA_WIDTH-1:0]      o_lut_bramctl_rdata;
  logic                        o_lut_bramctl_rvld;
`endif

  modport master (
    output i_lut_raddr, i_lut_rd_en, i_lut_bramctl_wdata, i_lut_bramctl_addr,
           i_lut_bramctl_we, i_lut_bramctl_en, i_swap_req,
    input  o_lut_dat, o_lut_dat_vld, o_swap_busy, o_active_bank, o_wr_err
`ifdef ACT_LUT_READBACK_EN
    , input o_lut_bramctl_rdata, o_lut_bramctl_rvld
`endif
  );

  modport slave (
    input  i_lut_raddr, i_lut_rd_en, i_lut_bramctl_wdata, i_lut_bramctl_addr,
           i_lut_bramctl_we, i_lut_bramctl_en, i_swap_req,
    output o_lut_dat, o_lut_dat_vld, o_swap_busy, o_active_bank, o_wr_err
`ifdef ACT_LUT_READBACK_EN
    , output o_lut_bramctl_rdata, o_lut_bramctl_rvld
`endif
  );
endinterface

// File: rtl/act_lut_pingpong.sv
// Two-bank multi-lane activation LUT: host reloads the shadow bank, swap waits for an idle read pipe; optional host readback via ACT_LUT_READBACK_EN.
// Read latency 1+OUT_REG cycles, one result per cycle; no backpressure, so continuous reads starve a pending swap.
module act_lut_pingpong #(
  parameter int LANES       = 32,
  parameter int LUT_WIDTH   = 24,
  parameter int LUT_DEPTH   = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int WDATA_WIDTH = 32,
  parameter int OUT_REG     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  act_lut_pingpong_if.slave lut_if
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(LUT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_SWAP} state_t;

  state_t                     r_state;
  logic                       r_active_bank;
  logic                       r_swap_busy;
  logic                       r_wr_err;
  logic                       r_vld1;
  logic [LANES*LUT_WIDTH-1:0] r_rd_dat;
  logic [LUT_WIDTH-1:0]       r_mem [2][LUT_DEPTH];
  logic [LANES*LUT_WIDTH-1:0] w_lane_dat;
  logic                       w_pipe_busy;
  logic                       w_host_in_range;
  logic                       w_host_wr;
  logic                       w_rd_drop;

  assign w_host_in_range = {1'b0, lut_if.i_lut_bramctl_addr} < DEPTH_C;
  assign w_host_wr       = lut_if.i_lut_bramctl_en & lut_if.i_lut_bramctl_we;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_addr = lut_if.i_lut_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_lane_dat[k*LUT_WIDTH +: LUT_WIDTH] =
      ({1'b0, w_addr} < DEPTH_C) ? r_mem[r_active_bank][w_addr] : '0;
  end

  if (WDATA_WIDTH > LUT_WIDTH) begin : g_wdata_hi
    logic w_unused_wdata_hi;
    assign w_unused_wdata_hi = ^lut_if.i_lut_bramctl_wdata[WDATA_WIDTH-1:LUT_WIDTH];
  end

  // Host writes only ever land in the shadow bank, so lane reads never collide with them.
  always_ff @(posedge i_clk) begin
    if (w_host_wr && w_host_in_range) begin
      r_mem[~r_active_bank][lut_if.i_lut_bramctl_addr] <= lut_if.i_lut_bramctl_wdata[LUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld1   <= 1'b0;
      r_rd_dat <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_vld1   <= lut_if.i_lut_rd_en;
      r_wr_err <= (w_host_wr & ~w_host_in_range) | w_rd_drop;
      if (lut_if.i_lut_rd_en) begin
        r_rd_dat <= w_lane_dat;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                       r_vld2;
    logic [LANES*LUT_WIDTH-1:0] r_out_dat;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld2    <= 1'b0;
        r_out_dat <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) begin
          r_out_dat <= r_rd_dat;
        end
      end
    end
    assign lut_if.o_lut_dat     = r_out_dat;
    assign lut_if.o_lut_dat_vld = r_vld2;
    assign w_pipe_busy          = r_vld1 | r_vld2;
  end else begin : g_no_out_reg
    assign lut_if.o_lut_dat     = r_rd_dat;
    assign lut_if.o_lut_dat_vld = r_vld1;
    assign w_pipe_busy          = r_vld1;
  end

  // The bank flips only on an edge with no read accepted and nothing left in the pipe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_swap_busy   <= 1'b0;
      r_active_bank <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lut_if.i_swap_req) begin
            r_state     <= S_PEND;
            r_swap_busy <= 1'b1;
          end
        end
        S_PEND: begin
          if (!lut_if.i_lut_rd_en && !w_pipe_busy) begin
            r_state       <= S_SWAP;
            r_active_bank <= ~r_active_bank;
          end
        end
        S_SWAP: begin
          r_state     <= S_IDLE;
          r_swap_busy <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_swap_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACT_LUT_READBACK_EN
  logic                   r_rb_vld;
  logic [WDATA_WIDTH-1:0] r_rb_dat;
  logic                   w_host_rd;

  assign w_host_rd = lut_if.i_lut_bramctl_en & ~lut_if.i_lut_bramctl_we;
  assign w_rd_drop = w_host_rd & ~w_host_in_range;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rb_vld <= 1'b0;
      r_rb_dat <= '0;
    end else begin
      r_rb_vld <= w_host_rd;
      if (w_host_rd) begin
        r_rb_dat <= w_host_in_range ?
                    WDATA_WIDTH'(r_mem[~r_active_bank][lut_if.i_lut_bramctl_addr]) : '0;
      end
    end
  end

  assign lut_if.o_lut_bramctl_rdata = r_rb_dat;
  assign lut_if.o_lut_bramctl_rvld  = r_rb_vld;
`else
  assign w_rd_drop = 1'b0;
`endif

  assign lut_if.o_swap_busy   = r_swap_busy;
  assign lut_if.o_active_bank = r_active_bank;
  assign lut_if.o_wr_err      = r_wr_err;
endmodule

// File: tb/tb_act_lut_pingpong.sv
// Directed bench for act_lut_pingpong with LUT_DEPTH=12 so out-of-range lanes and host writes are exercised.
module tb_act_lut_pingpong;
  localparam int LANES = 32;
  localparam int LW    = 24;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int WW    = 32;
  localparam int VW    = LANES*LW;
  localparam int RAW   = LANES*AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  act_lut_pingpong_if #(.LANES(LANES), .LUT_WIDTH(LW), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW)) bus_if ();

  act_lut_pingpong #(
    .LANES(LANES), .LUT_WIDTH(LW), .LUT_DEPTH(DEPTH),
    .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .OUT_REG(1)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .lut_if (bus_if)
  );

  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] m_bank [2][DEPTH];
  logic          exp_bank = 1'b0;
  logic [RAW-1:0] pat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic [RAW-1:0] addr_pat(input int base, input int stride);
    logic [RAW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*AW +: AW] = AW'((base + k*stride) % 16);
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_dat(input logic bank, input logic [RAW-1:0] av);
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    for (int k = 0; k < LANES; k++) begin
      a = av[k*AW +: AW];
      v[k*LW +: LW] = (a < DEPTH) ? m_bank[bank][a] : '0;
    end
    return v;
  endfunction

  task automatic host_wr(input logic [AW-1:0] addr, input logic [WW-1:0] d, input logic en, input logic we);
    bus_if.i_lut_bramctl_addr  = addr;
    bus_if.i_lut_bramctl_wdata = d;
    bus_if.i_lut_bramctl_en    = en;
    bus_if.i_lut_bramctl_we    = we;
    step();
    check1("wr_err", bus_if.o_wr_err, en & we & (addr >= DEPTH));
    if (en && we && addr < DEPTH) m_bank[~exp_bank][addr] = d[LW-1:0];
    bus_if.i_lut_bramctl_en = 1'b0;
    bus_if.i_lut_bramctl_we = 1'b0;
  endtask

  task automatic read_once(input logic [RAW-1:0] av);
    bus_if.i_lut_raddr = av;
    bus_if.i_lut_rd_en = 1'b1;
    step();
    bus_if.i_lut_rd_en = 1'b0;
    check1("rd_vld_early", bus_if.o_lut_dat_vld, 1'b0);
    step();
    check1("rd_vld", bus_if.o_lut_dat_vld, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.i_lut_raddr         = '0;
    bus_if.i_lut_rd_en         = 1'b0;
    bus_if.i_lut_bramctl_wdata = '0;
    bus_if.i_lut_bramctl_addr  = '0;
    bus_if.i_lut_bramctl_we    = 1'b0;
    bus_if.i_lut_bramctl_en    = 1'b0;
    bus_if.i_swap_req          = 1'b0;
    step();
    step();
    check("rst_dat", bus_if.o_lut_dat, '0);
    check1("rst_vld", bus_if.o_lut_dat_vld, 1'b0);
    check1("rst_busy", bus_if.o_swap_busy, 1'b0);
    check1("rst_bank", bus_if.o_active_bank, 1'b0);
    check1("rst_wr_err", bus_if.o_wr_err, 1'b0);
    rst = 1'b0;

    // Load shadow bank 1; addresses 12..15 are out of range and must raise wr_err.
    for (int i = 0; i < 16; i++) host_wr(AW'(i), 32'hFF00_0000 | (32'h10_0000 + i), 1'b1, 1'b1);
    step();
    check1("wr_err_clear", bus_if.o_wr_err, 1'b0);

    bus_if.i_swap_req = 1'b1;
    step();
    bus_if.i_swap_req = 1'b0;
    check1("swap1_busy", bus_if.o_swap_busy, 1'b1);
    check1("swap1_bank_pend", bus_if.o_active_bank, 1'b0);
    step();
    exp_bank = 1'b1;
    check1("swap1_bank", bus_if.o_active_bank, 1'b1);
    check1("swap1_busy_swap", bus_if.o_swap_busy, 1'b1);
    step();
    check1("swap1_busy_fall", bus_if.o_swap_busy, 1'b0);

    // Lane k reads addr k mod 16.
    read_once(addr_pat(0, 1));
    check("t1_dat", bus_if.o_lut_dat, exp_dat(1'b1, addr_pat(0, 1)));
    step();
    check1("t1_vld_low", bus_if.o_lut_dat_vld, 1'b0);
    check("t1_dat_hold", bus_if.o_lut_dat, exp_dat(1'b1, addr_pat(0, 1)));

    // 20 back-to-back reads, then idle.
    for (int r = 0; r < 22; r++) begin
      if (r < 20) begin
        bus_if.i_lut_raddr = addr_pat(r*3, 1);
        bus_if.i_lut_rd_en = 1'b1;
      end else begin
        bus_if.i_lut_rd_en = 1'b0;
      end
      step();
      check1("t2_vld", bus_if.o_lut_dat_vld, (r >= 1) && (r <= 20));
      if (r >= 1 && r <= 20) check("t2_dat", bus_if.o_lut_dat, exp_dat(1'b1, addr_pat((r-1)*3, 1)));
    end

    // Load bank 0, then request a swap while reads stream.
    for (int i = 0; i < DEPTH; i++) host_wr(AW'(i), 32'h20_0000 + i, 1'b1, 1'b1);
    bus_if.i_lut_raddr = addr_pat(0, 1);
    bus_if.i_lut_rd_en = 1'b1;
    step();
    bus_if.i_swap_req = 1'b1;
    step();
    bus_if.i_swap_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check1("t3_busy_starved", bus_if.o_swap_busy, 1'b1);
      check1("t3_bank_starved", bus_if.o_active_bank, 1'b1);
    end
    check("t3_dat_old_bank", bus_if.o_lut_dat, exp_dat(1'b1, addr_pat(0, 1)));
    bus_if.i_lut_rd_en = 1'b0;
    step();
    check1("t3_bank_drain1", bus_if.o_active_bank, 1'b1);
    step();
    check1("t3_bank_drain2", bus_if.o_active_bank, 1'b1);
    check1("t3_busy_drain2", bus_if.o_swap_busy, 1'b1);
    step();
    exp_bank = 1'b0;
    check1("t3_bank_swapped", bus_if.o_active_bank, 1'b0);
    check1("t3_busy_swap", bus_if.o_swap_busy, 1'b1);
    step();
    check1("t3_busy_fall", bus_if.o_swap_busy, 1'b0);

    // Shadow writes (bank 1) must not disturb reads of active bank 0; disabled writes are ignored.
    host_wr(AW'(3), 32'h00AB_CDEF, 1'b1, 1'b1);
    host_wr(AW'(4), 32'h0011_1111, 1'b0, 1'b1);
    host_wr(AW'(5), 32'h0022_2222, 1'b1, 1'b0);
    read_once(addr_pat(3, 0));
    check("t4_old_value", bus_if.o_lut_dat, exp_dat(1'b0, addr_pat(3, 0)));
    bus_if.i_swap_req = 1'b1;
    step();
    bus_if.i_swap_req = 1'b0;
    check1("t4_busy", bus_if.o_swap_busy, 1'b1);
    step();
    exp_bank = 1'b1;
    check1("t4_bank", bus_if.o_active_bank, 1'b1);
    bus_if.i_swap_req = 1'b1;
    step();
    bus_if.i_swap_req = 1'b0;
    check1("t4_busy_fall", bus_if.o_swap_busy, 1'b0);
    step();
    check1("t4_req_in_swap_ignored", bus_if.o_swap_busy, 1'b0);
    check1("t4_bank_stable", bus_if.o_active_bank, 1'b1);
    read_once(addr_pat(0, 1));
    check("t4_new_value", bus_if.o_lut_dat, exp_dat(1'b1, addr_pat(0, 1)));

    // One lane out of range; the others read addr 2.
    pat = addr_pat(2, 0);
    pat[7*AW +: AW] = 4'd14;
    read_once(pat);
    check("t5_lane_oor", bus_if.o_lut_dat, exp_dat(1'b1, pat));

    // Reset with a read in flight and a swap pending.
    bus_if.i_lut_raddr = addr_pat(0, 1);
    bus_if.i_lut_rd_en = 1'b1;
    bus_if.i_swap_req  = 1'b1;
    step();
    bus_if.i_lut_rd_en = 1'b0;
    bus_if.i_swap_req  = 1'b0;
    rst = 1'b1;
    step();
    exp_bank = 1'b0;
    check1("t6_vld", bus_if.o_lut_dat_vld, 1'b0);
    check1("t6_busy", bus_if.o_swap_busy, 1'b0);
    check1("t6_bank", bus_if.o_active_bank, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check1("t6_vld_after", bus_if.o_lut_dat_vld, 1'b0);
      check1("t6_busy_after", bus_if.o_swap_busy, 1'b0);
    end
    read_once(addr_pat(0, 1));
    check("t6_table_kept", bus_if.o_lut_dat, exp_dat(1'b0, addr_pat(0, 1)));
    check1("t6_bank_kept", bus_if.o_active_bank, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
